// File: rtl/params.sv
// Shared constants and types for the stm_timer / stm_swapchain segment path.
package params;

  localparam int          NumSegment  = 2;
  localparam int          IdxW        = 13;
  localparam logic [15:0] RepInfinite = 16'hFFFF;

  typedef enum logic [7:0] {
    TM_SYNC_IDX  = 8'h00,
    TM_SYS_TIME  = 8'h01,
    TM_IMMEDIATE = 8'hFF
  } transition_mode_t;

  function automatic logic mode_known(input logic [7:0] mode);
    return (mode == TM_SYNC_IDX) || (mode == TM_SYS_TIME) || (mode == TM_IMMEDIATE);
  endfunction

endpackage

// File: rtl/stm_swapchain.sv
// Selects which of two index streams is played, with triggered segment swaps
// and finite/infinite loop counting.
//
// state         | meaning
// INFINITE_LOOP | track IDX_IN[SEGMENT] forever
// WAIT_START    | swap requested, old segment still playing until trigger
// FINITE_LOOP   | track IDX_IN[SEGMENT], count wraps against latched REP
// STOPPED       | loop exhausted, IDX parked at CYCLE[SEGMENT], STOP high
module stm_swapchain
  import params::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            UPDATE_SETTINGS,
  input  logic            REQ_RD_SEGMENT,
  input  logic [7:0]      TRANSITION_MODE,
  input  logic [63:0]     TRANSITION_VALUE,
  input  logic [15:0]     REP,
  input  logic [63:0]     SYS_TIME,
  input  logic [IdxW-1:0] IDX_IN [NumSegment],
  input  logic [IdxW-1:0] CYCLE  [NumSegment],
  output logic            SEGMENT,
  output logic [IdxW-1:0] IDX,
  output logic            STOP
);

  typedef enum logic [1:0] {
    INFINITE_LOOP,
    WAIT_START,
    FINITE_LOOP,
    STOPPED
  } state_t;

  state_t           state, state_nxt;
  logic             seg_nxt;
  logic [15:0]      loop_cnt, loop_cnt_nxt;
  logic [15:0]      rep_q;
  transition_mode_t mode_q;
  logic [63:0]      tvalue_q;
  logic             req_q;
  logic [IdxW-1:0]  prev_idx [NumSegment];
  logic             upd_ok;
  logic             trig;
  logic             wrap;

  // An update carrying an unknown mode is dropped entirely, nothing is latched.
  assign upd_ok = UPDATE_SETTINGS && mode_known(TRANSITION_MODE);
  assign wrap   = IDX_IN[SEGMENT] < prev_idx[SEGMENT];

  always_comb begin
    trig = 1'b0;
    case (mode_q)
      TM_SYNC_IDX:  trig = (IDX_IN[req_q] == '0) && (prev_idx[req_q] != '0);
      TM_SYS_TIME:  trig = SYS_TIME >= tvalue_q;
      TM_IMMEDIATE: trig = 1'b1;
      default:      trig = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    seg_nxt      = SEGMENT;
    loop_cnt_nxt = loop_cnt;
    if (upd_ok) begin
      if (REQ_RD_SEGMENT == SEGMENT) begin
        loop_cnt_nxt = '0;
        state_nxt    = (REP == RepInfinite) ? INFINITE_LOOP : FINITE_LOOP;
      end else begin
        state_nxt = WAIT_START;
      end
    end else begin
      case (state)
        WAIT_START: begin
          if (trig) begin
            seg_nxt      = req_q;
            loop_cnt_nxt = '0;
            state_nxt    = (rep_q == RepInfinite) ? INFINITE_LOOP : FINITE_LOOP;
          end
        end
        FINITE_LOOP: begin
          if (wrap) begin
            if (loop_cnt == rep_q) state_nxt = STOPPED;
            else                   loop_cnt_nxt = loop_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= INFINITE_LOOP;
      SEGMENT  <= 1'b0;
      IDX      <= '0;
      STOP     <= 1'b0;
      loop_cnt <= '0;
      rep_q    <= RepInfinite;
      mode_q   <= TM_SYNC_IDX;
      tvalue_q <= '0;
      req_q    <= 1'b0;
      for (int i = 0; i < NumSegment; i++) prev_idx[i] <= '0;
    end else begin
      state    <= state_nxt;
      SEGMENT  <= seg_nxt;
      loop_cnt <= loop_cnt_nxt;
      if (upd_ok) begin
        req_q    <= REQ_RD_SEGMENT;
        mode_q   <= transition_mode_t'(TRANSITION_MODE);
        tvalue_q <= TRANSITION_VALUE;
        rep_q    <= REP;
      end
      for (int i = 0; i < NumSegment; i++) prev_idx[i] <= IDX_IN[i];
      // Output follows the next segment so a swap and its first index share an edge.
      IDX  <= (state_nxt == STOPPED) ? CYCLE[seg_nxt] : IDX_IN[seg_nxt];
      STOP <= (state_nxt == STOPPED);
    end
  end

endmodule
